// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the control FSM encoding and the width of one arithmetic slice.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add4.sv
// One 4-bit ripple slice with carry-in/carry-out; purely combinational.
// Shared by every nibble of an operation, one nibble per clock.
module nibble_add4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    assign sum   = total[NIBBLE_W-1:0];
    assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial W-bit adder: one nibble per clock through a single shared 4-bit slice.
// Result and flags are registered; done pulses one cycle, NIBBLES edges after start.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    input  logic                         cin,
    output logic                         busy,
    output logic                         done,
    output logic [NIBBLE_W*NIBBLES-1:0]  sum,
    output logic                         cout,
    output logic                         ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t                             state_q;
    logic [IDX_W-1:0]                   idx_q;
    logic [IDX_W-1:0]                   idx_d;
    logic                               carry_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   sum_q;
    logic                               cout_q;
    logic                               ovf_q;
    logic                               ovf_d;
    logic                               busy_q;
    logic                               done_q;

    logic [NIBBLE_W-1:0]                add_a;
    logic [NIBBLE_W-1:0]                add_b;
    logic [NIBBLE_W-1:0]                add_sum;
    logic                               add_cout;

    assign add_a = a_q[idx_q];
    assign add_b = b_q[idx_q];

    nibble_add4 u_add (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign idx_d = idx_q + IDX_W'(1);

    // Only meaningful on the last nibble: add_sum[MSB] is then the result sign bit.
    assign ovf_d = (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                   (add_sum[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= add_sum;
                    carry_q      <= add_cout;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        cout_q  <= add_cout;
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_d;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = W'(sum_q);
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with NIBBLES=4.
// Inputs change 1ns after a rising edge; outputs are checked at the same point.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_assert;
    int n_fail;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, scramble the inputs while it runs, then check
    // latency, busy width, result and the single-cycle done pulse.
    task automatic op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                      input logic vc, input logic [15:0] es, input logic ec, input logic eo);
        int cycles;
        int busy_cnt;
        a = va; b = vb; cin = vc; start = 1'b1;
        step();
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; cin = ~vc;
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 12) begin
            if (busy) busy_cnt++;
            step();
            cycles++;
        end
        chk({tag, "_latency"}, 32'(cycles), 32'd4);
        chk({tag, "_done"},    32'(done), 32'd1);
        chk({tag, "_busycnt"}, 32'(busy_cnt), 32'd4);
        chk({tag, "_sum"},     {16'h0, sum}, {16'h0, es});
        chk({tag, "_cout"},    32'(cout), 32'(ec));
        chk({tag, "_ovf"},     32'(ovf), 32'(eo));
        step();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"},  32'(busy), 32'd0);
        chk({tag, "_hold_sum"},   {16'h0, sum}, {16'h0, es});
    endtask

    initial begin
        int cycles;
        int done_cnt;
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
        step();
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  {16'h0, sum}, 32'h0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf",  32'(ovf), 32'd0);

        // Reset wins over a simultaneous start.
        start = 1'b1; a = 16'h1111; b = 16'h1111;
        step();
        chk("rst_vs_start_busy", 32'(busy), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        step();
        chk("idle_no_start_busy", 32'(busy), 32'd0);

        op("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op("ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Reset in the second RUN cycle aborts with no done pulse.
        a = 16'h0101; b = 16'h0202; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_sum",  {16'h0, sum}, 32'h0);
        chk("abort_cout", 32'(cout), 32'd0);
        chk("abort_ovf",  32'(ovf), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            step();
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_idle",    32'(busy), 32'd0);

        op("cin",   16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);

        // A start two cycles into RUN must not disturb the latched operands.
        a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_busy", 32'(busy), 32'd1);
        step();
        step();
        chk("ign_done", 32'(done), 32'd1);
        chk("ign_sum",  {16'h0, sum}, 32'h3333);
        chk("ign_cout", 32'(cout), 32'd0);
        step();
        chk("ign_after_busy", 32'(busy), 32'd0);

        // Back-to-back: start held high through RUN and DONE.
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        step();
        a = 16'h0008; b = 16'h0008;
        cycles = 0;
        while (!done && cycles < 12) begin
            step();
            cycles++;
        end
        chk("b2b_first_latency", 32'(cycles), 32'd4);
        chk("b2b_first_sum",     {16'h0, sum}, 32'h0003);
        step();
        start = 1'b0;
        chk("b2b_no_idle_busy", 32'(busy), 32'd1);
        chk("b2b_no_idle_done", 32'(done), 32'd0);
        cycles = 0;
        while (!done && cycles < 12) begin
            step();
            cycles++;
        end
        // DONE occupies one edge, then four RUN edges to the second done.
        chk("b2b_second_gap", 32'(cycles + 1), 32'd5);
        chk("b2b_second_sum", {16'h0, sum}, 32'h0010);
        chk("b2b_second_cout", 32'(cout), 32'd0);
        chk("b2b_second_ovf",  32'(ovf), 32'd0);
        step();
        chk("b2b_end_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
